// File: rtl/sam_vaddr_if.sv
// sam_vaddr_if: VDG timing strobes, SAM mode/offset inputs and the
// generated video address, bundled between timing source and generator.
interface sam_vaddr_if;
    logic        da0;
    logic        hs_n;
    logic        fs_n;
    logic [2:0]  mode;
    logic [6:0]  disp_offset;
    logic [15:0] vaddr;
    logic        frame_start;

    modport master (
        output da0, hs_n, fs_n, mode, disp_offset,
        input  vaddr, frame_start
    );

    modport slave (
        input  da0, hs_n, fs_n, mode, disp_offset,
        output vaddr, frame_start
    );
endinterface

// File: rtl/sam_vaddr.sv
// sam_vaddr: CoCo2 SAM video address generator.
// Builds the display fetch address from the SAM offset and repeats
// graphics rows according to the latched VDG mode (X/Y divide).
// Optional macro SAM_VADDR_CLAMP32K_EN keeps every address in the low 32K
// (bit 15 forced to 0, increment wraps 0x7FFF -> 0x0000).
module sam_vaddr (
    input  logic         clk,
    input  logic         reset,
    sam_vaddr_if.slave   bus
);

`ifdef SAM_VADDR_CLAMP32K_EN
    localparam logic [15:0] ADDR_MASK = 16'h7FFF;
`else
    localparam logic [15:0] ADDR_MASK = 16'hFFFF;
`endif

    // Address increment: wraps within the addressable window, no carry out.
    function automatic logic [15:0] addr_inc(input logic [15:0] a);
        return (a + 16'd1) & ADDR_MASK;
    endfunction

    logic [15:0] vaddr_q,     vaddr_d;
    logic [15:0] row_start_q, row_start_d;
    logic        x_cnt_q,     x_cnt_d;
    logic [3:0]  y_cnt_q,     y_cnt_d;
    logic [2:0]  mode_q,      mode_d;
    logic        frame_start_q, frame_start_d;
    logic        da0_prev_q,  da0_prev_d;
    logic        hs_n_prev_q, hs_n_prev_d;
    logic        fs_n_prev_q, fs_n_prev_d;

    logic        da0_rise;
    logic        hs_fall;
    logic        fs_fall;
    logic        x_div2;
    logic [3:0]  y_last;

    // Strobe edges against the previous-cycle copies.
    always_comb begin
        da0_rise = bus.da0 & ~da0_prev_q;
        hs_fall  = ~bus.hs_n & hs_n_prev_q;
        fs_fall  = ~bus.fs_n & fs_n_prev_q;
    end

    // Divisor decode from the mode latched at frame start (y_last = ydiv-1).
    always_comb begin
        x_div2 = 1'b0;
        y_last = 4'd0;
        case (mode_q)
            3'b000: begin x_div2 = 1'b0; y_last = 4'd11; end
            3'b001: begin x_div2 = 1'b0; y_last = 4'd2;  end
            3'b010: begin x_div2 = 1'b1; y_last = 4'd2;  end
            3'b011: begin x_div2 = 1'b0; y_last = 4'd2;  end
            3'b100: begin x_div2 = 1'b1; y_last = 4'd1;  end
            3'b101: begin x_div2 = 1'b0; y_last = 4'd1;  end
            default: begin x_div2 = 1'b0; y_last = 4'd0; end
        endcase
    end

    // Next-state: frame start beats line end beats byte fetch; losers are dropped.
    always_comb begin
        vaddr_d       = vaddr_q;
        row_start_d   = row_start_q;
        x_cnt_d       = x_cnt_q;
        y_cnt_d       = y_cnt_q;
        mode_d        = mode_q;
        frame_start_d = 1'b0;
        da0_prev_d    = bus.da0;
        hs_n_prev_d   = bus.hs_n;
        fs_n_prev_d   = bus.fs_n;

        if (fs_fall) begin
            vaddr_d       = {bus.disp_offset, 9'b0} & ADDR_MASK;
            row_start_d   = {bus.disp_offset, 9'b0} & ADDR_MASK;
            x_cnt_d       = 1'b0;
            y_cnt_d       = 4'd0;
            mode_d        = bus.mode;
            frame_start_d = 1'b1;
        end else if (hs_fall) begin
            x_cnt_d = 1'b0;
            if (y_cnt_q == y_last) begin
                // Row finished: next row begins where this scanline ended.
                y_cnt_d     = 4'd0;
                row_start_d = vaddr_q;
            end else begin
                // Row still repeating: rewind to its first byte.
                y_cnt_d = y_cnt_q + 4'd1;
                vaddr_d = row_start_q;
            end
        end else if (da0_rise) begin
            if (x_div2) begin
                x_cnt_d = ~x_cnt_q;
                if (x_cnt_q) begin
                    vaddr_d = addr_inc(vaddr_q);
                end
            end else begin
                vaddr_d = addr_inc(vaddr_q);
            end
        end
    end

    // State register with synchronous reset; strobe history resets to idle levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            vaddr_q       <= 16'h0000;
            row_start_q   <= 16'h0000;
            x_cnt_q       <= 1'b0;
            y_cnt_q       <= 4'd0;
            mode_q        <= 3'b000;
            frame_start_q <= 1'b0;
            da0_prev_q    <= 1'b0;
            hs_n_prev_q   <= 1'b1;
            fs_n_prev_q   <= 1'b1;
        end else begin
            vaddr_q       <= vaddr_d;
            row_start_q   <= row_start_d;
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            mode_q        <= mode_d;
            frame_start_q <= frame_start_d;
            da0_prev_q    <= da0_prev_d;
            hs_n_prev_q   <= hs_n_prev_d;
            fs_n_prev_q   <= fs_n_prev_d;
        end
    end

    assign bus.vaddr       = vaddr_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_sam_vaddr.sv
// tb_sam_vaddr: directed and randomized bench for sam_vaddr with a
// row/fetch-count reference model.
module tb_sam_vaddr;

`ifdef SAM_VADDR_CLAMP32K_EN
    localparam int MASK = 32'h7FFF;
`else
    localparam int MASK = 32'hFFFF;
`endif

    logic clk;
    logic reset;
    sam_vaddr_if bus();

    sam_vaddr dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: address = row base + (bytes fetched this line / xdiv).
    int       m_base;
    int       m_fetch;
    int       m_line;
    logic [2:0] m_mode;
    logic     m_fs;
    logic     p_da0, p_hs, p_fs;

    function automatic int xdiv_of(input logic [2:0] m);
        case (m)
            3'b010, 3'b100: return 2;
            default:        return 1;
        endcase
    endfunction

    function automatic int ydiv_of(input logic [2:0] m);
        case (m)
            3'b000:                 return 12;
            3'b001, 3'b010, 3'b011: return 3;
            3'b100, 3'b101:         return 2;
            default:                return 1;
        endcase
    endfunction

    function automatic logic [15:0] exp_vaddr();
        int v;
        v = (m_base + m_fetch / xdiv_of(m_mode)) & MASK;
        return v[15:0];
    endfunction

    task automatic model_reset();
        m_base  = 0;
        m_fetch = 0;
        m_line  = 0;
        m_mode  = 3'b000;
        m_fs    = 1'b0;
        p_da0   = 1'b0;
        p_hs    = 1'b1;
        p_fs    = 1'b1;
    endtask

    // One clock: drive strobes, take the edge, advance the model, settle.
    task automatic cyc(input logic d, input logic h, input logic f);
        logic rda, fh, ff;
        bus.da0  = d;
        bus.hs_n = h;
        bus.fs_n = f;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            rda  = d & ~p_da0;
            fh   = ~h & p_hs;
            ff   = ~f & p_fs;
            m_fs = ff;
            if (ff) begin
                m_base  = {16'd0, bus.disp_offset, 9'b0} & MASK;
                m_fetch = 0;
                m_line  = 0;
                m_mode  = bus.mode;
            end else if (fh) begin
                if (m_line + 1 == ydiv_of(m_mode)) begin
                    m_base = int'(exp_vaddr());
                    m_line = 0;
                end else begin
                    m_line = m_line + 1;
                end
                m_fetch = 0;
            end else if (rda) begin
                m_fetch = m_fetch + 1;
            end
            p_da0 = d;
            p_hs  = h;
            p_fs  = f;
        end
        #1;
    endtask

    task automatic da_rises(input int n);
        repeat (n) begin
            cyc(1'b1, 1'b1, 1'b1);
            cyc(1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic hs_pulse();
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.vaddr !== 16'h0000) begin
            errors++; $display("FAIL reset_vaddr got=%h exp=0000", bus.vaddr);
        end
        checks++;
        if (bus.frame_start !== 1'b0) begin
            errors++; $display("FAIL reset_frame_start got=%b exp=0", bus.frame_start);
        end
        reset = 1'b0;
        repeat (4) cyc(1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.vaddr !== 16'h0000) begin
            errors++; $display("FAIL idle_vaddr got=%h exp=0000", bus.vaddr);
        end
        // da0 held high: only the first cycle is an edge.
        repeat (4) cyc(1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.vaddr !== 16'h0001) begin
            errors++; $display("FAIL held_da0 got=%h exp=0001", bus.vaddr);
        end
        // hs_n held low: a single rewind to the row start.
        repeat (3) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.vaddr !== 16'h0000 || bus.frame_start !== 1'b0) begin
            errors++; $display("FAIL held_hs got=%h/%b exp=0000/0", bus.vaddr, bus.frame_start);
        end
    endtask

    task automatic test_mode0();
        bus.disp_offset = 7'h02;
        bus.mode        = 3'b000;
        cyc(1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.vaddr !== 16'h0400 || bus.frame_start !== 1'b1) begin
            errors++; $display("FAIL m0_frame got=%h/%b exp=0400/1", bus.vaddr, bus.frame_start);
        end
        cyc(1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.frame_start !== 1'b0) begin
            errors++; $display("FAIL m0_fs_pulse got=%b exp=0", bus.frame_start);
        end
        da_rises(32);
        checks++;
        if (bus.vaddr !== 16'h0420) begin
            errors++; $display("FAIL m0_line got=%h exp=0420", bus.vaddr);
        end
        for (int i = 1; i <= 11; i++) begin
            hs_pulse();
            checks++;
            if (bus.vaddr !== 16'h0400) begin
                errors++; $display("FAIL m0_repeat%0d got=%h exp=0400", i, bus.vaddr);
            end
            da_rises(32);
        end
        hs_pulse();
        checks++;
        if (bus.vaddr !== 16'h0420) begin
            errors++; $display("FAIL m0_row_wrap got=%h exp=0420", bus.vaddr);
        end
        da_rises(5);
        hs_pulse();
        checks++;
        if (bus.vaddr !== 16'h0420) begin
            errors++; $display("FAIL m0_new_row_start got=%h exp=0420", bus.vaddr);
        end
    endtask

    task automatic test_mode2();
        bus.disp_offset = 7'h00;
        bus.mode        = 3'b010;
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        da_rises(1);
        checks++;
        if (bus.vaddr !== 16'h0000) begin
            errors++; $display("FAIL m2_first_rise got=%h exp=0000", bus.vaddr);
        end
        da_rises(31);
        checks++;
        if (bus.vaddr !== 16'h0010) begin
            errors++; $display("FAIL m2_line got=%h exp=0010", bus.vaddr);
        end
        for (int i = 1; i <= 2; i++) begin
            hs_pulse();
            checks++;
            if (bus.vaddr !== 16'h0000) begin
                errors++; $display("FAIL m2_repeat%0d got=%h exp=0000", i, bus.vaddr);
            end
            da_rises(32);
        end
        hs_pulse();
        checks++;
        if (bus.vaddr !== 16'h0010) begin
            errors++; $display("FAIL m2_third_hs got=%h exp=0010", bus.vaddr);
        end
    endtask

    task automatic test_mode6();
        bus.disp_offset = 7'h00;
        bus.mode        = 3'b110;
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        repeat (3) begin
            da_rises(32);
            hs_pulse();
        end
        checks++;
        if (bus.vaddr !== 16'h0060) begin
            errors++; $display("FAIL m6_no_rewind got=%h exp=0060", bus.vaddr);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] base;
        logic [15:0] top;
`ifdef SAM_VADDR_CLAMP32K_EN
        base = 16'h7E00;
        top  = 16'h7FFF;
`else
        base = 16'hFE00;
        top  = 16'hFFFF;
`endif
        bus.disp_offset = 7'h7F;
        bus.mode        = 3'b110;
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.vaddr !== base) begin
            errors++; $display("FAIL wrap_base got=%h exp=%h", bus.vaddr, base);
        end
        da_rises(511);
        checks++;
        if (bus.vaddr !== top) begin
            errors++; $display("FAIL wrap_top got=%h exp=%h", bus.vaddr, top);
        end
        da_rises(1);
        checks++;
        if (bus.vaddr !== 16'h0000) begin
            errors++; $display("FAIL wrap_zero got=%h exp=0000", bus.vaddr);
        end
    endtask

    task automatic test_priority();
        // Previous frame leaves the row counter non-zero.
        bus.disp_offset = 7'h03;
        bus.mode        = 3'b101;
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        da_rises(4);
        hs_pulse();
        da_rises(3);
        // All three strobe edges in one cycle.
        bus.disp_offset = 7'h05;
        cyc(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.vaddr !== 16'h0A00 || bus.frame_start !== 1'b1) begin
            errors++; $display("FAIL prio_frame got=%h/%b exp=0a00/1", bus.vaddr, bus.frame_start);
        end
        cyc(1'b0, 1'b1, 1'b1);
        da_rises(4);
        hs_pulse();
        checks++;
        if (bus.vaddr !== 16'h0A00) begin
            errors++; $display("FAIL prio_ycnt_cleared got=%h exp=0a00", bus.vaddr);
        end
        // Mode/offset changes mid-frame are ignored until the next frame.
        bus.disp_offset = 7'h00;
        bus.mode        = 3'b110;
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        bus.mode        = 3'b000;
        bus.disp_offset = 7'h11;
        da_rises(4);
        hs_pulse();
        checks++;
        if (bus.vaddr !== 16'h0004) begin
            errors++; $display("FAIL midframe_mode got=%h exp=0004", bus.vaddr);
        end
    endtask

    task automatic test_reset_midframe();
        bus.disp_offset = 7'h09;
        bus.mode        = 3'b001;
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        da_rises(7);
        reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        checks++;
        if (bus.vaddr !== 16'h0000 || bus.frame_start !== 1'b0) begin
            errors++; $display("FAIL midreset got=%h/%b exp=0000/0", bus.vaddr, bus.frame_start);
        end
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.vaddr !== 16'h0000) begin
            errors++; $display("FAIL post_reset_idle got=%h exp=0000", bus.vaddr);
        end
    endtask

    task automatic test_random();
        logic d, h, f;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 4) bus.mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 4) bus.disp_offset = 7'($urandom_range(0, 127));
            reset = ($urandom_range(0, 999) < 3);
            d = 1'($urandom_range(0, 1));
            h = ($urandom_range(0, 99) >= 6);
            f = ($urandom_range(0, 999) >= 8);
            cyc(d, h, f);
            checks++;
            if (bus.vaddr !== exp_vaddr()) begin
                errors++; $display("FAIL rand_vaddr i=%0d got=%h exp=%h", i, bus.vaddr, exp_vaddr());
            end
            checks++;
            if (bus.frame_start !== m_fs) begin
                errors++; $display("FAIL rand_frame_start i=%0d got=%b exp=%b", i, bus.frame_start, m_fs);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.da0         = 1'b0;
        bus.hs_n        = 1'b1;
        bus.fs_n        = 1'b1;
        bus.mode        = 3'b000;
        bus.disp_offset = 7'h00;
        model_reset();
        test_reset();
        test_mode0();
        test_mode2();
        test_mode6();
        test_wrap();
        test_priority();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sam_vaddr.md
# sam_vaddr

Video address generator for the CoCo2 SAM: it produces the 16-bit display-memory address the VDG fetches from. Consumes the SAM display offset (F6..F0, 512-byte pages) and VDG mode bits (V2..V0), plus the VDG timing strobes DA0, HS_n and FS_n. Output `vaddr` feeds the video side of the RAM address mux. It implements the per-mode X/Y divide so that graphics rows repeat the correct number of scanlines.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock, same domain as SAM/VDG strobes
- reset  in  1  synchronous, active-high
- da0  in  1  VDG display address clock; rising edge = one byte fetched
- hs_n  in  1  VDG horizontal sync, active low; falling edge = end of scanline
- fs_n  in  1  VDG field sync, active low; falling edge = start of frame
- mode  in  3  SAM VDG mode bits V2..V0
- disp_offset  in  7  SAM display offset F6..F0, 512-byte pages
- vaddr  out  16  current video fetch address
- frame_start  out  1  one-clock pulse on the cycle the frame base is loaded

## Operation
- Inputs are synchronous to clk. Edges are detected against a one-cycle-delayed copy: rise(da0) = da0 & ~da0_d, fall(x) = ~x & x_d.
- Mode latched at each frame start into mode_l. It selects divisors:
  - 000 ÷1/÷12
  - 001 ÷1/÷3
  - 010 ÷2/÷3
  - 011 ÷1/÷3
  - 100 ÷2/÷2
  - 101 ÷1/÷2
  - 110 ÷1/÷1
  - 111 ÷1/÷1
- Divisors are xdiv/ydiv.
- Frame start, on fall(fs_n):
  - vaddr <= row_start <= {disp_offset, 9'b0}
  - x_cnt <= 0, y_cnt <= 0
  - mode_l <= mode
  - frame_start <= 1
- Line end, on fall(hs_n) without fs fall:
  - x_cnt <= 0
  - If y_cnt == ydiv-1: y_cnt <= 0, row_start <= vaddr; vaddr keeps advancing from that point.
  - Else: y_cnt <= y_cnt+1, vaddr <= row_start, so the row repeats.
- Byte fetch, on rise(da0) without fs or hs fall:
  - xdiv=1: vaddr <= vaddr+1.
  - xdiv=2: x_cnt toggles; vaddr increments only when x_cnt was 1, i.e. on every second rise. The first increment comes on the 2nd rise after a line or frame start.
- Priority within one cycle: fs fall > hs fall > da0 rise. A lower-priority event in the same cycle is discarded, not deferred.
- Arithmetic: vaddr increment is modulo 2^16, so 0xFFFF -> 0x0000. There is no carry into other state.
- disp_offset and mode changes mid-frame have no effect until the next fs fall.

## Timing
- Reset values:
  - vaddr=0x0000, row_start=0x0000
  - x_cnt=0, y_cnt=0, mode_l=000
  - frame_start=0
  - da0_d=0, hs_n_d=1, fs_n_d=1
- Latency: an input edge present at clk edge n updates vaddr/frame_start at edge n; the result is visible after edge n. There is one register stage, no pipeline.
- frame_start is high exactly one cycle per fs fall and 0 otherwise.
- Level-held strobes produce no repeated action. An edge requires a change from the previous cycle.
- Reset asserted mid-frame returns everything to reset values on the next edge. After release, the held-high strobe history means no spurious edge is detected.
- y_cnt never exceeds ydiv-1. It is cleared only by frame start or wrap.

## Configuration
- SAM_VADDR_CLAMP32K_EN
- Defined: vaddr[15] is forced to 0 everywhere, including row_start and frame base, so {disp_offset,9'b0} & 0x7FFF. Increment wraps 0x7FFF -> 0x0000.
- Undefined: full 16-bit behaviour as above.

## Test plan
- Reset -> vaddr=0x0000, frame_start=0; strobes held high/low produce no change.
- disp_offset=7'h02, mode=000, fs fall -> vaddr=0x0400 and a 1-cycle frame_start. Then:
  - 32 da0 rises -> 0x0420.
  - 11 hs falls, each followed by 32 da0 -> vaddr back to 0x0400 after each.
  - 12th hs fall -> row_start=0x0420.
- mode=010, fs fall with offset 0: 32 da0 rises -> vaddr=0x0010. hs fall -> 0x0000 (row repeats until the 3rd hs).
- mode=110, offset 0: 32 da0 then hs fall, repeated 3 times -> vaddr=0x0060 and never rewinds.
- offset=7'h7F, mode=110, 512 da0 rises -> vaddr=0x0000 (wrap from 0xFFFF). With the macro, base=0x7E00 and wraps 0x7FFF -> 0x0000.
- fs fall, hs fall and da0 rise in the same cycle -> vaddr=base and y_cnt=0; the da0/hs events are discarded. Changing mode mid-frame has no effect until the next fs.
